// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the single register-file write port between two writeback
//            requesters (port 0 = ALU, port 1 = load). It also keeps a busy
//            scoreboard of destinations that were reserved at issue.
//
// Ports    : clk, rst (async, active-low)
//            req{0,1}_valid/_rd/_data  writeback requests (held until ready)
//            req{0,1}_ready            grant, combinational from valid
//            issue_valid/issue_rd      reserves a destination register
//            write/writeR/write_data   registered regfile write port
//            busy[NREG]                scoreboard, busy[0] always 0
//            wb_err                    sticky: writeback to an unreserved reg
//
// Config   : WB_RR_EN  defined   -> round-robin tie-break
//                      undefined -> fixed priority, port 0 wins ties
// Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [4:0]      req0_rd,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [4:0]      req1_rd,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            write,
    output logic [4:0]      writeR,
    output logic [XLEN-1:0] write_data,
    output logic [NREG-1:0] busy,
    output logic            wb_err
);

    logic            grant0;
    logic            grant1;
    logic            xfer;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            sel_nz;
    logic            err_hit;
    logic [NREG-1:0] busy_next;

`ifdef WB_RR_EN
    // last = 1 means port 1 was granted most recently, so port 0 wins a tie.
    logic last;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        // Grants are masked while reset is held so nothing transfers.
        if (rst) begin
            if (req0_valid && req1_valid) begin
                grant0 = last;
                grant1 = ~last;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= 1'b1;
        end else if (xfer) begin
            last <= grant1;
        end
    end
`else
    always_comb begin
        grant0 = rst & req0_valid;
        grant1 = rst & req1_valid & ~req0_valid;
    end
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 | grant1;

    always_comb begin
        sel_rd   = grant1 ? req1_rd   : req0_rd;
        sel_data = grant1 ? req1_data : req0_data;
        sel_nz   = (sel_rd != 5'd0);
        // Busy is sampled before this edge's clear, so a write to a register
        // that was never reserved is flagged.
        err_hit  = xfer & sel_nz & ~busy[sel_rd];
    end

    // Clear first, then set: a reservation issued on the same edge survives.
    always_comb begin
        busy_next = busy;
        if (xfer && sel_nz) begin
            busy_next[sel_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write      <= 1'b0;
            writeR     <= 5'd0;
            write_data <= '0;
            busy       <= '0;
            wb_err     <= 1'b0;
        end else begin
            // x0 requests are accepted but never reach the regfile.
            write <= xfer & sel_nz;
            if (xfer && sel_nz) begin
                writeR     <= sel_rd;
                write_data <= sel_data;
            end
            busy <= busy_next;
            if (err_hit) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Self-checking bench for regfile_wb_arbiter. Directed scenarios
//            with literal expectations, then randomized traffic checked every
//            cycle against a behavioural model (bit array scoreboard, grant
//            rule, expected write register).
// Config   : honours WB_RR_EN the same way as the design.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

`ifdef WB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_rd, req1_rd;
    logic [63:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        write;
    logic [4:0]  writeR;
    logic [63:0] write_data;
    logic [31:0] busy;
    logic        wb_err;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_rd    (req0_rd),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rd    (req1_rd),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .write      (write),
        .writeR     (writeR),
        .write_data (write_data),
        .busy       (busy),
        .wb_err     (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    bit          mb[32];
    bit          m_write;
    logic [4:0]  m_writeR;
    logic [63:0] m_wdata;
    bit          m_err;
    int          m_last;

    always @(negedge clk) begin : compare
        int          w;
        logic [4:0]  rd;
        logic [31:0] bv;
        for (int i = 0; i < 32; i++) bv[i] = mb[i];
        if (!rst) begin
            check("rst ready0", req0_ready, 0);
            check("rst ready1", req1_ready, 0);
            check("rst write", write, 0);
            check("rst writeR", writeR, 0);
            check("rst wdata", write_data, 0);
            check("rst busy", busy, 0);
            check("rst wb_err", wb_err, 0);
            for (int i = 0; i < 32; i++) mb[i] = 1'b0;
            m_write = 0; m_writeR = 0; m_wdata = 0; m_err = 0; m_last = 1;
        end else begin
            if (req0_valid && req1_valid) w = RR ? (m_last == 0 ? 1 : 0) : 0;
            else if (req0_valid)          w = 0;
            else if (req1_valid)          w = 1;
            else                          w = -1;
            check("m ready0", req0_ready, (w == 0));
            check("m ready1", req1_ready, (w == 1));
            check("m write", write, m_write);
            if (m_write) begin
                check("m writeR", writeR, m_writeR);
                check("m wdata", write_data, m_wdata);
            end
            check("m busy", busy, bv);
            check("m wb_err", wb_err, m_err);
            // advance the model to the state after the coming edge
            m_write = 0;
            if (w >= 0) begin
                rd     = (w == 1) ? req1_rd : req0_rd;
                m_last = w;
                if (rd != 0) begin
                    m_write  = 1;
                    m_writeR = rd;
                    m_wdata  = (w == 1) ? req1_data : req0_data;
                    if (!mb[rd]) m_err = 1;
                    mb[rd] = 1'b0;
                end
            end
            if (issue_valid && issue_rd != 0) mb[issue_rd] = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 0;
        req0_valid = 0; req1_valid = 0; issue_valid = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic issue_one(input logic [4:0] r);
        issue_valid = 1; issue_rd = r;
        tick();
        issue_valid = 0;
    endtask

    initial begin : drive
        int          expg;
        logic [31:0] b_save;
        logic        e_save;
        logic        f0, f1;
        rst = 1;
        req0_valid = 0; req1_valid = 0; issue_valid = 0;
        req0_rd = 0; req1_rd = 0; issue_rd = 0;
        req0_data = 0; req1_data = 0;
        #2 rst = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1;

        // single ALU write
        issue_one(5'd5);
        check("t1 busy5 set", busy[5], 1);
        req0_valid = 1; req0_rd = 5; req0_data = 64'hDEADBEEF_00000001;
        #1 check("t1 ready0", req0_ready, 1);
        tick();
        req0_valid = 0;
        check("t1 write", write, 1);
        check("t1 writeR", writeR, 5);
        check("t1 wdata", write_data, 64'hDEADBEEF_00000001);
        check("t1 busy5 clr", busy[5], 0);
        check("t1 wb_err", wb_err, 0);

        // contention
        do_reset();
        issue_one(5'd3);
        issue_one(5'd4);
        req0_valid = 1; req0_rd = 3; req0_data = 64'h3333;
        req1_valid = 1; req1_rd = 4; req1_data = 64'h4444;
        for (int k = 0; k < 4; k++) begin
            expg = RR ? (k % 2) : 0;
            issue_valid = 1; issue_rd = (expg == 0) ? 5'd3 : 5'd4;
            #1;
            check("cont ready0", req0_ready, (expg == 0));
            check("cont ready1", req1_ready, (expg == 1));
            tick();
            check("cont writeR", writeR, (expg == 0) ? 3 : 4);
        end
        issue_valid = 0; req0_valid = 0; req1_valid = 0;

        // x0 write
        tick();
        req1_valid = 1; req1_rd = 0; req1_data = 64'hFF;
        #1 check("x0 ready1", req1_ready, 1);
        b_save = busy; e_save = wb_err;
        tick();
        req1_valid = 0;
        check("x0 write", write, 0);
        check("x0 busy", busy, b_save);
        check("x0 wb_err", wb_err, e_save);

        // simultaneous set/clear
        issue_one(5'd7);
        issue_valid = 1; issue_rd = 7;
        req0_valid = 1; req0_rd = 7; req0_data = 64'h7777;
        #1 check("sc ready0", req0_ready, 1);
        tick();
        issue_valid = 0; req0_valid = 0;
        check("sc write", write, 1);
        check("sc writeR", writeR, 7);
        check("sc busy7", busy[7], 1);

        // unreserved writeback, then reset mid-operation
        do_reset();
        for (int r = 4; r < 8; r++) issue_one(r[4:0]);
        req0_valid = 1; req0_rd = 9; req0_data = 64'h9999;
        tick();
        req0_valid = 0;
        check("ue write", write, 1);
        check("ue wb_err", wb_err, 1);
        tick(); tick();
        check("ue wb_err held", wb_err, 1);
        req0_valid = 1; req0_rd = 9; req0_data = 64'h1234_5678_9ABC_DEF0;
        tick();
        req0_valid = 0;
        check("rm write pre", write, 1);
        check("rm busy pre", busy, 32'h0000_00F0);
        #2 rst = 0;
        #1;
        check("rm write", write, 0);
        check("rm writeR", writeR, 0);
        check("rm wdata", write_data, 0);
        check("rm busy", busy, 0);
        check("rm wb_err", wb_err, 0);
        req0_valid = 1; req0_rd = 1; req0_data = 64'h1;
        req1_valid = 1; req1_rd = 2; req1_data = 64'h2;
        #1;
        check("rm ready0 in rst", req0_ready, 0);
        check("rm ready1 in rst", req1_ready, 0);
        @(posedge clk); #1 rst = 1;
        #1;
        check("rm first tie 0", req0_ready, 1);
        check("rm first tie 1", req1_ready, 0);
        tick();
        req0_valid = 0; req1_valid = 0;

        // randomized traffic, three phases each starting from reset
        for (int ph = 0; ph < 3; ph++) begin
            do_reset();
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                f0 = req0_valid & req0_ready;
                f1 = req1_valid & req1_ready;
                @(posedge clk);
                #1;
                if (!req0_valid || f0) begin
                    req0_valid = ($urandom_range(0, 99) < 60);
                    req0_rd    = 5'($urandom_range(0, 7));
                    req0_data  = {$urandom(), $urandom()};
                end
                if (!req1_valid || f1) begin
                    req1_valid = ($urandom_range(0, 99) < 60);
                    req1_rd    = 5'($urandom_range(0, 7));
                    req1_data  = {$urandom(), $urandom()};
                end
                issue_valid = ($urandom_range(0, 99) < 50);
                issue_rd    = 5'($urandom_range(0, 9));
            end
            req0_valid = 0; req1_valid = 0; issue_valid = 0;
            tick();
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
